udp_pixel_stream_writer: RTL

//  Parametrised UDP-to-panel write engine. Sits between the UDP core source stream and the panel

---
 rtl/udp_pixel_stream_writer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/udp_pixel_stream_writer.sv
// udp_pixel_stream_writer
//   Turns the UDP core's source stream into panel write commands. Each beat
//   carries one payload byte. Bytes are assembled MSB-first into fixed-size
//   pixel words. Every complete word becomes one RGB write, issued to the set
//   of panels selected by the low bits of the destination port. A packet is
//   dropped when its destination port does not match or when it carries a
//   beat with an error flag.
//
//   Optional feature: define UDP_PIXEL_STATS_EN to add the packet counters
//   pkt_ok_count / pkt_drop_count. Without the macro these ports and their
//   counters do not exist, and nothing else changes.
//
// Ports
//   clock                  in   single clock, posedge
//   reset                  in   asynchronous, active-high
//   udp_source_valid       in   beat valid
//   udp_source_last        in   last beat of the packet
//   udp_source_ready       out  beat accept (high from the first clock after reset)
//   udp_source_src_port    in   unused
//   udp_source_dst_port    in   [15:8] must equal PORT_MSB, [NUM_PANELS-1:0] panel mask
//   udp_source_ip_address  in   unused
//   udp_source_length      in   unused
//   udp_source_data        in   payload byte in [7:0]
//   udp_source_error       in   nonzero marks a corrupt beat
//   ctrl_en                out  one-cycle write strobe per panel
//   ctrl_wr                out  constant write-RGB command
//   ctrl_addr              out  pixel address, zero-extended
//   ctrl_wdat              out  {R,G,B}, each channel zero-extended to 8 bits
//   led_reg                out  toggles once per accepted packet
//   pkt_ok_count           out  accepted packets   (UDP_PIXEL_STATS_EN only)
//   pkt_drop_count         out  dropped packets    (UDP_PIXEL_STATS_EN only)

module udp_pixel_stream_writer #(
    parameter logic [7:0] PORT_MSB   = 8'h66,
    parameter int         NUM_PANELS = 6,
    parameter int         ADDR_W     = 14,
    parameter int         COLOR_W    = 6,
    parameter int         WORD_BYTES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  udp_source_valid,
    input  logic                  udp_source_last,
    output logic                  udp_source_ready,
    input  logic [15:0]           udp_source_src_port,
    input  logic [15:0]           udp_source_dst_port,
    input  logic [31:0]           udp_source_ip_address,
    input  logic [15:0]           udp_source_length,
    input  logic [31:0]           udp_source_data,
    input  logic [3:0]            udp_source_error,
    output logic [NUM_PANELS-1:0] ctrl_en,
    output logic [3:0]            ctrl_wr,
    output logic [15:0]           ctrl_addr,
    output logic [23:0]           ctrl_wdat,
    output logic                  led_reg
`ifdef UDP_PIXEL_STATS_EN
    ,
    output logic [15:0]           pkt_ok_count,
    output logic [15:0]           pkt_drop_count
`endif
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [NUM_PANELS-1:0] mask_q, mask_d;
    logic                  ready_q;
    logic [NUM_PANELS-1:0] ctrl_en_q, ctrl_en_d;
    logic [15:0]           ctrl_addr_q, ctrl_addr_d;
    logic [23:0]           ctrl_wdat_q, ctrl_wdat_d;
    logic                  led_q, led_d;
    logic                  pkt_ok_inc, pkt_drop_inc;

    logic                  beat;
    logic                  port_ok;
    logic                  beat_err;
    logic [WORD_W-1:0]     word_shift;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  take_byte;
    logic                  clear_cnt;

    // Fields of an assembled word, MSB first: addr, R, G, B, then ignored pad.
    function automatic logic [15:0] word_addr(input logic [WORD_W-1:0] w);
        logic [ADDR_W-1:0] a;
        a = w[WORD_W-1 -: ADDR_W];
        return 16'(a);
    endfunction

    function automatic logic [23:0] word_rgb(input logic [WORD_W-1:0] w);
        logic [COLOR_W-1:0] r, g, b;
        r = w[WORD_W-1-ADDR_W -: COLOR_W];
        g = w[WORD_W-1-ADDR_W-COLOR_W -: COLOR_W];
        b = w[WORD_W-1-ADDR_W-2*COLOR_W -: COLOR_W];
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    assign beat       = udp_source_valid && ready_q;
    assign port_ok    = (udp_source_dst_port[15:8] == PORT_MSB);
    assign beat_err   = |udp_source_error;
    assign word_shift = (word_q << 8) | WORD_W'(udp_source_data[7:0]);
    assign cnt_inc    = byte_cnt_q + CNT_W'(1);

    // Inputs that carry nothing this engine needs.
    logic unused_inputs;
    assign unused_inputs = ^{udp_source_src_port, udp_source_ip_address,
                             udp_source_length, udp_source_data[31:8],
                             udp_source_dst_port[7:0]};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        mask_d       = mask_q;
        ctrl_en_d    = '0;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdat_d  = ctrl_wdat_q;
        led_d        = led_q;
        pkt_ok_inc   = 1'b0;
        pkt_drop_inc = 1'b0;
        take_byte    = 1'b0;
        clear_cnt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (port_ok && !beat_err) begin
                        mask_d = udp_source_dst_port[NUM_PANELS-1:0];
                        if (udp_source_last) begin
                            // Single-beat packet: accepted but the lone byte
                            // can never form a word, so it is discarded.
                            clear_cnt  = 1'b1;
                            led_d      = ~led_q;
                            pkt_ok_inc = 1'b1;
                        end else begin
                            take_byte = 1'b1;
                            state_d   = DATA;
                        end
                    end else if (udp_source_last) begin
                        pkt_drop_inc = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end

            DATA: begin
                if (beat) begin
                    if (beat_err) begin
                        clear_cnt = 1'b1;
                        if (udp_source_last) begin
                            state_d      = IDLE;
                            pkt_drop_inc = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        take_byte = 1'b1;
                        if (udp_source_last) begin
                            // A word completed by this beat is still written;
                            // any leftover partial word is thrown away.
                            state_d    = IDLE;
                            clear_cnt  = 1'b1;
                            led_d      = ~led_q;
                            pkt_ok_inc = 1'b1;
                        end
                    end
                end
            end

            DROP: begin
                if (beat && udp_source_last) begin
                    state_d      = IDLE;
                    pkt_drop_inc = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                clear_cnt = 1'b1;
            end
        endcase

        if (take_byte) begin
            word_d = word_shift;
            if (cnt_inc == CNT_W'(WORD_BYTES)) begin
                byte_cnt_d  = '0;
                ctrl_en_d   = mask_d;
                ctrl_addr_d = word_addr(word_shift);
                ctrl_wdat_d = word_rgb(word_shift);
            end else begin
                byte_cnt_d = cnt_inc;
            end
        end

        if (clear_cnt) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            mask_q      <= '0;
            ready_q     <= 1'b0;
            ctrl_en_q   <= '0;
            ctrl_addr_q <= '0;
            ctrl_wdat_q <= '0;
            led_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            mask_q      <= mask_d;
            ready_q     <= 1'b1;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_addr_q <= ctrl_addr_d;
            ctrl_wdat_q <= ctrl_wdat_d;
            led_q       <= led_d;
        end
    end

    // Assembly shift register: only meaningful bytes are ever read out, so it
    // needs no reset.
    always_ff @(posedge clock) begin
        word_q <= word_d;
    end

    assign udp_source_ready = ready_q;
    assign ctrl_en          = ctrl_en_q;
    assign ctrl_wr          = 4'b0111;
    assign ctrl_addr        = ctrl_addr_q;
    assign ctrl_wdat        = ctrl_wdat_q;
    assign led_reg          = led_q;

`ifdef UDP_PIXEL_STATS_EN
    logic [15:0] pkt_ok_q, pkt_drop_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_ok_q   <= '0;
            pkt_drop_q <= '0;
        end else begin
            if (pkt_ok_inc) begin
                pkt_ok_q <= pkt_ok_q + 16'd1;
            end
            if (pkt_drop_inc) begin
                pkt_drop_q <= pkt_drop_q + 16'd1;
            end
        end
    end

    assign pkt_ok_count   = pkt_ok_q;
    assign pkt_drop_count = pkt_drop_q;
`else
    logic unused_stats;
    assign unused_stats = pkt_ok_inc ^ pkt_drop_inc;
`endif

endmodule
